// File: rtl/time_pkg.sv
// time_pkg: shared state encoding and time constants for the time counter family.
package time_pkg;
    typedef enum logic [1:0] {ST_SET, ST_RUN, ST_EXPIRED} state_t;
    localparam int SECS_PER_MIN = 60;
    localparam int MOD_HOUR = 3600;
endpackage

// File: rtl/count_split.sv
// count_split: combinational split of a seconds count into minutes and seconds.
module count_split
    import time_pkg::*;
#(
    parameter int W  = 12,
    parameter int MW = 7
) (
    input  logic [W-1:0]  i_count,
    output logic [MW-1:0] o_min,
    output logic [5:0]    o_sec
);
    logic [W-1:0] w_min;
    logic [W-1:0] w_sec;
    assign w_min = i_count / W'(SECS_PER_MIN);
    assign w_sec = i_count % W'(SECS_PER_MIN);
    assign o_min = MW'(w_min);
    assign o_sec = w_sec[5:0];
endmodule

// File: rtl/time_counter_p.sv
// time_counter_p: modulo-MOD up/down time counter advanced by a 1 Hz tick,
// with validated set-mode loading, wrap pulse and countdown expiry.
module time_counter_p
    import time_pkg::*;
#(
    parameter int MOD          = MOD_HOUR,
    parameter int W            = 12,
    parameter int MW           = 7,
    parameter int STOP_AT_ZERO = 0,
    parameter int RESET_VALUE  = 0
) (
    input  logic          CLOCK,
    input  logic          RESET_N,
    input  logic          TICK,
    input  logic          ENABLE,
    input  logic          TIME_FLOWS,
    input  logic          DIR,
    input  logic [W-1:0]  SET_TIME,
    output logic [W-1:0]  count,
    output logic          WRAP,
    output logic          EXPIRED,
    output logic          SET_CLAMPED,
    output logic [MW-1:0] MIN_OUT,
    output logic [5:0]    SEC_OUT
);
    localparam logic [W-1:0] MAX = W'(MOD - 1);

    state_t       r_state, w_state;
    logic [W-1:0] r_count, w_count;
    logic         r_wrap, w_wrap;
    logic         r_expired, w_expired;
    logic         r_clamped, w_clamped;
    logic         w_tick;

    assign w_tick = TICK & TIME_FLOWS;

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state   <= ST_SET;
            r_count   <= W'(RESET_VALUE);
            r_wrap    <= 1'b0;
            r_expired <= 1'b0;
            r_clamped <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_count   <= w_count;
            r_wrap    <= w_wrap;
            r_expired <= w_expired;
            r_clamped <= w_clamped;
        end
    end

    always_comb begin
        w_state   = r_state;
        w_count   = r_count;
        w_wrap    = 1'b0;
        w_expired = r_expired;
        w_clamped = r_clamped;
        if (!ENABLE) begin
            w_state   = ST_SET;
            w_count   = (SET_TIME > MAX) ? MAX : SET_TIME;
            w_clamped = SET_TIME > MAX;
            w_expired = 1'b0;
        end else begin
            case (r_state)
                ST_SET: w_state = ST_RUN;
                ST_RUN: begin
                    if (w_tick && !DIR) begin
                        w_count = (r_count == MAX) ? '0 : r_count + 1'b1;
                        w_wrap  = r_count == MAX;
                    end else if (w_tick && r_count != '0) begin
                        w_count = r_count - 1'b1;
                        if (STOP_AT_ZERO != 0 && r_count == W'(1)) begin
                            w_expired = 1'b1;
                            w_state   = ST_EXPIRED;
                        end
                    end else if (w_tick && STOP_AT_ZERO != 0) begin
                        w_expired = 1'b1;
                        w_state   = ST_EXPIRED;
                    end else if (w_tick) begin
                        w_count = MAX;
                        w_wrap  = 1'b1;
                    end
                end
                ST_EXPIRED: w_state = ST_EXPIRED;
                default: w_state = ST_SET;
            endcase
        end
    end

    assign count       = r_count;
    assign WRAP        = r_wrap;
    assign EXPIRED     = r_expired;
    assign SET_CLAMPED = r_clamped;

    count_split #(.W(W), .MW(MW)) u_split (
        .i_count (r_count),
        .o_min   (MIN_OUT),
        .o_sec   (SEC_OUT)
    );
endmodule

// File: tb/tb_time_counter_p.sv
// tb_time_counter_p: directed checks of wrapping and stop-at-zero counters.
module tb_time_counter_p;
    logic        CLOCK = 1'b0;
    logic        RESET_N;
    logic        TICK;
    logic        ENABLE;
    logic        TIME_FLOWS;
    logic        DIR;
    logic [11:0] SET_TIME;

    logic [11:0] cnt0, cnt1;
    logic        wrap0, wrap1, exp0, exp1, clamp0, clamp1;
    logic [6:0]  min0, min1;
    logic [5:0]  sec0, sec1;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 CLOCK = ~CLOCK;

    time_counter_p #(.STOP_AT_ZERO(0)) dut0 (
        .CLOCK(CLOCK), .RESET_N(RESET_N), .TICK(TICK), .ENABLE(ENABLE),
        .TIME_FLOWS(TIME_FLOWS), .DIR(DIR), .SET_TIME(SET_TIME),
        .count(cnt0), .WRAP(wrap0), .EXPIRED(exp0), .SET_CLAMPED(clamp0),
        .MIN_OUT(min0), .SEC_OUT(sec0)
    );

    time_counter_p #(.STOP_AT_ZERO(1)) dut1 (
        .CLOCK(CLOCK), .RESET_N(RESET_N), .TICK(TICK), .ENABLE(ENABLE),
        .TIME_FLOWS(TIME_FLOWS), .DIR(DIR), .SET_TIME(SET_TIME),
        .count(cnt1), .WRAP(wrap1), .EXPIRED(exp1), .SET_CLAMPED(clamp1),
        .MIN_OUT(min1), .SEC_OUT(sec1)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic cyc(input logic t);
        TICK = t;
        @(posedge CLOCK);
        #1;
        TICK = 1'b0;
    endtask

    initial begin
        RESET_N = 1'b0; TICK = 1'b0; ENABLE = 1'b0; TIME_FLOWS = 1'b1;
        DIR = 1'b0; SET_TIME = 12'd1234;
        #12;
        check("reset_count", cnt0, 0);
        check("reset_flags", {wrap0, exp0, clamp0, exp1}, 0);
        RESET_N = 1'b1;
        cyc(0);
        check("set_1234", cnt0, 1234);
        ENABLE = 1'b1;
        cyc(0);
        cyc(1);
        check("run_1235", cnt0, 1235);
        #2 RESET_N = 1'b0;
        #1;
        check("async_reset_count", cnt0, 0);
        check("async_reset_flags", {wrap0, exp0, clamp0}, 0);
        RESET_N = 1'b1;
        cyc(1);
        check("entry_tick_ignored", cnt0, 0);
        cyc(1);
        check("first_tick", cnt0, 1);

        ENABLE = 1'b0; SET_TIME = 12'd3599;
        cyc(0);
        check("set_3599", cnt0, 3599);
        check("set_3599_clamp", clamp0, 0);
        check("min_3599", min0, 59);
        check("sec_3599", sec0, 59);
        ENABLE = 1'b1;
        cyc(0);
        cyc(1);
        check("up_wrap_count", cnt0, 0);
        check("up_wrap_pulse", wrap0, 1);
        check("up_wrap_split", {min0, sec0}, 0);
        cyc(0);
        check("up_wrap_one_cycle", wrap0, 0);

        ENABLE = 1'b0; SET_TIME = 12'd4000;
        cyc(0);
        check("clamp_count", cnt0, 3599);
        check("clamp_flag", clamp0, 1);
        SET_TIME = 12'd3600;
        cyc(0);
        check("clamp_boundary", {clamp0, cnt0}, {1'b1, 12'd3599});
        SET_TIME = 12'd125;
        cyc(0);
        check("set_125", cnt0, 125);
        check("set_125_clamp", clamp0, 0);
        check("min_125", min0, 2);
        check("sec_125", sec0, 5);

        SET_TIME = 12'd1;
        cyc(0);
        ENABLE = 1'b1; DIR = 1'b1;
        cyc(0);
        cyc(1);
        check("down_to_0", cnt0, 0);
        check("down_to_0_nowrap", wrap0, 0);
        check("saz_1_to_0_exp", {exp1, cnt1}, {1'b1, 12'd0});
        cyc(1);
        check("down_wrap_count", cnt0, 3599);
        check("down_wrap_pulse", wrap0, 1);
        check("down_wrap_noexp", exp0, 0);
        check("saz_hold", {exp1, wrap1, cnt1}, {1'b1, 1'b0, 12'd0});

        ENABLE = 1'b0; SET_TIME = 12'd2;
        cyc(0);
        check("saz_set_clears_exp", exp1, 0);
        ENABLE = 1'b1;
        cyc(0);
        cyc(1);
        check("saz_count_1", {exp1, cnt1}, {1'b0, 12'd1});
        cyc(1);
        check("saz_expire", {exp1, wrap1, cnt1}, {1'b1, 1'b0, 12'd0});
        cyc(1);
        check("saz_third_tick", {exp1, wrap1, cnt1}, {1'b1, 1'b0, 12'd0});
        DIR = 1'b0;
        cyc(1);
        check("saz_dir_ignored", {exp1, cnt1}, {1'b1, 12'd0});
        ENABLE = 1'b0; SET_TIME = 12'd10;
        cyc(0);
        check("saz_exit", {exp1, cnt1}, {1'b0, 12'd10});

        ENABLE = 1'b1;
        cyc(0);
        TIME_FLOWS = 1'b0;
        for (int i = 0; i < 5; i++) cyc(1);
        check("pause", cnt0, 10);
        TIME_FLOWS = 1'b1;
        cyc(1);
        check("dir_up_11", cnt0, 11);
        DIR = 1'b1;
        cyc(1);
        check("dir_down_10", cnt0, 10);
        DIR = 1'b0;
        cyc(1);
        check("dir_up_11b", cnt0, 11);
        check("clamp_held", clamp0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule

// File: doc/time_counter_p.md
Name: time_counter_p

Overview:
- Parametrised successor of the 1 s seconds-of-hour counter.
- Modulo-MOD time counter running on the system clock, advanced by a 1 Hz TICK strobe. Supports up-count (clock) and down-count (timer) modes.
- Provides validated set-mode loading, a wrap pulse, an expiry flag for countdown, and minute/second split outputs.
- Sits between the mode controller (ENABLE, DIR, SET_TIME) and the display and alarm comparators.

Parameters:
MOD, 3600, count modulus; count range 0..MOD-1; MOD >= 2
W, 12, count width; 2^W >= MOD required
MW, 7, width of MIN_OUT; must hold (MOD-1)/60
STOP_AT_ZERO, 0, 1 = down-count halts at 0 and raises EXPIRED; 0 = down-count wraps to MOD-1
RESET_VALUE, 0, count value after reset; must be < MOD

Ports:
CLOCK  in  1  system clock; all state updates on posedge
RESET_N  in  1  asynchronous, active-low reset
TICK  in  1  one-CLOCK-cycle 1 Hz strobe
ENABLE  in  1  0 = set mode (count tracks SET_TIME); 1 = run
TIME_FLOWS  in  1  1 = time advances on TICK; 0 = pause
DIR  in  1  0 = up, 1 = down
SET_TIME  in  W  value loaded in set mode
count  out  W  current count
WRAP  out  1  one-cycle pulse on modulo wrap
EXPIRED  out  1  level; countdown reached 0 with STOP_AT_ZERO=1
SET_CLAMPED  out  1  level; last set-mode load was clamped
MIN_OUT  out  MW  count / 60, combinational from count
SEC_OUT  out  6  count % 60, combinational from count

Behaviour:
- Reset (RESET_N=0, async):
  - count=RESET_VALUE, WRAP=0, EXPIRED=0, SET_CLAMPED=0, state=ST_SET.
  - Release is sampled at the next posedge.
- States: ST_SET, ST_RUN, ST_EXPIRED. ENABLE=0 in any state forces ST_SET at the next edge; this has priority over everything except reset.
- ST_SET, every CLOCK edge with ENABLE=0:
  - If SET_TIME < MOD: count<=SET_TIME, SET_CLAMPED<=0.
  - Otherwise: count<=MOD-1, SET_CLAMPED<=1.
  - TICK is ignored. WRAP<=0. EXPIRED<=0.
- ST_SET with ENABLE=1:
  - Go to ST_RUN; count holds.
  - A TICK in this transition cycle is ignored (one-cycle entry latency).
- ST_RUN, edge with TICK=1 and TIME_FLOWS=1:
  - DIR=0: if count==MOD-1, count<=0 and WRAP<=1; else count+1.
  - DIR=1, count!=0: count-1.
    - With STOP_AT_ZERO=1, reaching 0 (1->0) sets EXPIRED<=1 and goes to ST_EXPIRED on the same edge.
  - DIR=1, count==0, STOP_AT_ZERO=0: count<=MOD-1, WRAP<=1.
  - DIR=1, count==0, STOP_AT_ZERO=1: count stays 0, EXPIRED<=1, go to ST_EXPIRED. WRAP is not asserted.
- ST_RUN without a qualifying tick: count holds, WRAP<=0.
- ST_EXPIRED:
  - count holds 0 and EXPIRED stays 1; TICK, DIR and TIME_FLOWS are ignored.
  - Exit only via ENABLE=0 (to ST_SET, EXPIRED cleared) or reset.
- WRAP: registered, high for exactly one CLOCK cycle, never two consecutive cycles (TICK is a single-cycle strobe).
- A DIR change takes effect at the next qualifying TICK; there is no extra latency.
- Arithmetic is W-bit unsigned. count never leaves 0..MOD-1, including when SET_TIME >= 2^W-range values are applied.
- SET_CLAMPED holds its value outside ST_SET.

Decomposition:
- Shared package time_pkg: state encoding (ST_SET, ST_RUN, ST_EXPIRED), constant SECS_PER_MIN=60, default MOD_HOUR=3600.
- One sub-module, count_split (combinational divide/modulo by 60, parametrised W, MW), produces MIN_OUT and SEC_OUT. It is reused by the alarm-time display path.

Test Plan:
- Reset mid-run with count=1234 -> count=0 asynchronously, all flags 0. After release with ENABLE=1, the first TICK is ignored (entry cycle); the next TICK gives count=1.
- ENABLE=0, SET_TIME=3599 -> count=3599, SET_CLAMPED=0. Then ENABLE=1, DIR=0, TIME_FLOWS=1, one TICK -> count=0, WRAP high exactly one cycle, MIN_OUT=0, SEC_OUT=0.
- ENABLE=0, SET_TIME=4000 -> count=3599, SET_CLAMPED=1. Then SET_TIME=125 -> count=125, SET_CLAMPED=0, MIN_OUT=2, SEC_OUT=5.
- STOP_AT_ZERO=0, set count=1, DIR=1, two TICKs -> count 0, then 3599 with WRAP pulse; EXPIRED stays 0.
- STOP_AT_ZERO=1, set count=2, DIR=1, three TICKs -> count 1, then 0 with EXPIRED=1 and no WRAP; third TICK leaves count=0. Then ENABLE=0 -> EXPIRED=0.
- Running, TIME_FLOWS=0 for 5 TICKs -> count unchanged. Toggle DIR between TICKs from count=10 -> sequence 11, 10, 11 per DIR.
